// File: rtl/droop_brake_sched.sv
// droop_brake_sched: debounces masked droop requests from NUM_SRC sources and drives the
// single brake input of the droop/recovery manager. It enforces a minimum brake width,
// waits for the manager to report BRAKES_OFF (with a timeout), then applies a re-arm holdoff.
// Optional feature: define DROOP_BRAKE_SCHED_PENDING_EN to latch a request seen during
// WAIT_DONE/HOLDOFF and issue it without debounce on re-arm.

package droop_brake_pkg;
  typedef enum logic [1:0] {
    BRAKES_OFF = 2'd0,
    BRAKING    = 2'd1,
    RECOVERING = 2'd2
  } brake_state_t;
endpackage

module droop_brake_sched
  import droop_brake_pkg::*;
#(
  parameter int unsigned NUM_SRC          = 4,
  parameter int unsigned DEBOUNCE_CYCLES  = 3,
  parameter int unsigned MIN_BRAKE_CYCLES = 8,
  parameter int unsigned DONE_TIMEOUT     = 4096,
  parameter int unsigned HOLDOFF_CYCLES   = 64,
  parameter int unsigned CNT_W            = 16,
  localparam int unsigned SrcW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               refclk,
  input  logic               resetn,
  input  logic               enable,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic [NUM_SRC-1:0] droop_req,
  input  brake_state_t       brake_state,
  input  logic               clear_status,
  output logic               brake,
  output logic [SrcW-1:0]    brake_src,
  output logic               sched_busy,
  output logic [CNT_W-1:0]   event_count,
  output logic               timeout_err
);

  localparam int unsigned DebW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DebW-1:0] DebMax = DebW'(DEBOUNCE_CYCLES - 1);

  // The timer is shared by ASSERT, WAIT_DONE and HOLDOFF; size it for the largest load.
  localparam int unsigned TLoadA = MIN_BRAKE_CYCLES - 1;
  localparam int unsigned TLoadW = DONE_TIMEOUT - 1;
  localparam int unsigned TLoadH = HOLDOFF_CYCLES;
  localparam int unsigned TMaxAW = (TLoadA > TLoadW) ? TLoadA : TLoadW;
  localparam int unsigned TMax   = (TMaxAW > TLoadH) ? TMaxAW : TLoadH;
  localparam int unsigned TimW   = (TMax > 1) ? $clog2(TMax + 1) : 1;

  typedef enum logic [1:0] {StArmed, StAssert, StWaitDone, StHoldoff} state_e;

  state_e             state_q, state_d;
  logic [TimW-1:0]    timer_q, timer_d;
  logic [DebW-1:0]    cnt_q [NUM_SRC];
  logic [DebW-1:0]    cnt_d [NUM_SRC];
  logic               brake_q, brake_d;
  logic [SrcW-1:0]    src_q, src_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               terr_q, terr_d;

  logic [NUM_SRC-1:0] masked;
  logic [NUM_SRC-1:0] qual;
  logic               issue;
  logic [SrcW-1:0]    issue_src;

`ifdef DROOP_BRAKE_SCHED_PENDING_EN
  logic               pend_vld_q, pend_vld_d;
  logic [SrcW-1:0]    pend_idx_q, pend_idx_d;
  logic               pend_hit;
  logic [SrcW-1:0]    pend_sel;
`endif

  function automatic logic [SrcW-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    logic [SrcW-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = SrcW'(i);
    end
    return idx;
  endfunction

  assign masked = droop_req & src_mask;

  // Per-source qualification: the DEBOUNCE_CYCLES-th consecutive masked high sample.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      qual[i] = masked[i] & (cnt_q[i] == DebMax);
    end
  end

  // Next-state, debounce, timer and status logic.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    brake_d   = brake_q;
    src_d     = src_q;
    count_d   = count_q;
    terr_d    = terr_q;
    issue     = 1'b0;
    issue_src = '0;
    for (int i = 0; i < NUM_SRC; i++) cnt_d[i] = '0;
`ifdef DROOP_BRAKE_SCHED_PENDING_EN
    pend_vld_d = pend_vld_q;
    pend_idx_d = pend_idx_q;
    pend_hit   = pend_vld_q | (|masked);
    pend_sel   = pend_vld_q ? pend_idx_q : lowest_idx(masked);
`endif

    if (clear_status) begin
      count_d = '0;
      terr_d  = 1'b0;
    end

    if (!enable) begin
      // Abort: the droop manager finishes its own recovery.
      state_d = StArmed;
      timer_d = '0;
      brake_d = 1'b0;
`ifdef DROOP_BRAKE_SCHED_PENDING_EN
      pend_vld_d = 1'b0;
      pend_idx_d = '0;
`endif
    end else begin
      unique case (state_q)
        StArmed: begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (!masked[i])              cnt_d[i] = '0;
            else if (cnt_q[i] == DebMax) cnt_d[i] = DebMax;
            else                         cnt_d[i] = cnt_q[i] + 1'b1;
          end
          if (|qual) begin
            issue     = 1'b1;
            issue_src = lowest_idx(qual);
          end
        end
        StAssert: begin
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else if (masked == '0) begin
            brake_d = 1'b0;
            timer_d = TimW'(DONE_TIMEOUT - 1);
            state_d = StWaitDone;
          end
        end
        StWaitDone: begin
`ifdef DROOP_BRAKE_SCHED_PENDING_EN
          pend_vld_d = pend_hit;
          pend_idx_d = pend_sel;
`endif
          if (brake_state == BRAKES_OFF) begin
            timer_d = TimW'(HOLDOFF_CYCLES);
            state_d = StHoldoff;
          end else if (timer_q == '0) begin
            terr_d  = 1'b1;
            timer_d = TimW'(HOLDOFF_CYCLES);
            state_d = StHoldoff;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        StHoldoff: begin
`ifdef DROOP_BRAKE_SCHED_PENDING_EN
          pend_vld_d = pend_hit;
          pend_idx_d = pend_sel;
`endif
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else begin
            state_d = StArmed;
`ifdef DROOP_BRAKE_SCHED_PENDING_EN
            if (pend_hit) begin
              issue      = 1'b1;
              issue_src  = pend_sel;
              pend_vld_d = 1'b0;
              pend_idx_d = '0;
            end
`endif
          end
        end
        default: state_d = StArmed;
      endcase
    end

    if (issue) begin
      brake_d = 1'b1;
      src_d   = issue_src;
      timer_d = TimW'(MIN_BRAKE_CYCLES - 1);
      state_d = StAssert;
      for (int i = 0; i < NUM_SRC; i++) cnt_d[i] = '0;
      if (count_d != {CNT_W{1'b1}}) count_d = count_d + 1'b1;
    end
  end

  // State and status registers.
  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StArmed;
      timer_q <= '0;
      brake_q <= 1'b0;
      src_q   <= '0;
      count_q <= '0;
      terr_q  <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
`ifdef DROOP_BRAKE_SCHED_PENDING_EN
      pend_vld_q <= 1'b0;
      pend_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      brake_q <= brake_d;
      src_q   <= src_d;
      count_q <= count_d;
      terr_q  <= terr_d;
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
`ifdef DROOP_BRAKE_SCHED_PENDING_EN
      pend_vld_q <= pend_vld_d;
      pend_idx_q <= pend_idx_d;
`endif
    end
  end

  assign brake       = brake_q;
  assign brake_src   = src_q;
  assign sched_busy  = (state_q != StArmed);
  assign event_count = count_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_droop_brake_sched.sv
// tb_droop_brake_sched: directed stimulus with a cycle-level behavioural model compared against
// the DUT every cycle, plus literal expectations for latency, width, timing and saturation.
module tb_droop_brake_sched;
  import droop_brake_pkg::*;

  localparam int NSRC = 4;
  localparam int DEB  = 3;
  localparam int MINB = 8;
  localparam int DTO  = 4096;
  localparam int HOLD = 64;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            refclk;
  logic            resetn;
  logic            enable;
  logic [NSRC-1:0] src_mask;
  logic [NSRC-1:0] droop_req;
  brake_state_t    brake_state;
  logic            clear_status;
  logic            brake;
  logic [1:0]      brake_src;
  logic            sched_busy;
  logic [CW-1:0]   event_count;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  droop_brake_sched #(
    .NUM_SRC         (NSRC),
    .DEBOUNCE_CYCLES (DEB),
    .MIN_BRAKE_CYCLES(MINB),
    .DONE_TIMEOUT    (DTO),
    .HOLDOFF_CYCLES  (HOLD),
    .CNT_W           (CW)
  ) dut (
    .refclk      (refclk),
    .resetn      (resetn),
    .enable      (enable),
    .src_mask    (src_mask),
    .droop_req   (droop_req),
    .brake_state (brake_state),
    .clear_status(clear_status),
    .brake       (brake),
    .brake_src   (brake_src),
    .sched_busy  (sched_busy),
    .event_count (event_count),
    .timeout_err (timeout_err)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s wait expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 armed, 1 braking, 2 waiting for recovery, 3 holdoff.
  // m_n counts edges spent in the current phase; run_len counts consecutive masked highs.
  int m_phase, m_n, m_src, m_count, m_pend;
  bit m_brake, m_terr;
  int run_len [NSRC];

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_src = 0; m_count = 0; m_pend = -1;
    m_brake = 0; m_terr = 0;
    for (int i = 0; i < NSRC; i++) run_len[i] = 0;
  endtask

  task automatic model_step();
    logic [NSRC-1:0] mk;
    bit issue;
    int isrc;
    mk = droop_req & src_mask;
    issue = 0;
    isrc = 0;
    if (clear_status) begin
      m_count = 0;
      m_terr  = 0;
    end
    if (!enable) begin
      m_phase = 0; m_n = 0; m_brake = 0; m_pend = -1;
      for (int i = 0; i < NSRC; i++) run_len[i] = 0;
    end else begin
`ifdef DROOP_BRAKE_SCHED_PENDING_EN
      if ((m_phase == 2 || m_phase == 3) && m_pend < 0) begin
        for (int i = NSRC - 1; i >= 0; i--) if (mk[i]) m_pend = i;
      end
`endif
      case (m_phase)
        0: begin
          for (int i = 0; i < NSRC; i++) run_len[i] = mk[i] ? run_len[i] + 1 : 0;
          for (int i = NSRC - 1; i >= 0; i--) begin
            if (run_len[i] >= DEB) begin
              issue = 1;
              isrc  = i;
            end
          end
        end
        1: begin
          m_n++;
          if (m_n >= MINB && mk == '0) begin
            m_brake = 0; m_phase = 2; m_n = 0;
          end
        end
        2: begin
          m_n++;
          if (brake_state == BRAKES_OFF) begin
            m_phase = 3; m_n = 0;
          end else if (m_n >= DTO) begin
            m_terr = 1; m_phase = 3; m_n = 0;
          end
        end
        default: begin
          m_n++;
          if (m_n >= HOLD + 1) begin
            m_phase = 0; m_n = 0;
            if (m_pend >= 0) begin
              issue  = 1;
              isrc   = m_pend;
              m_pend = -1;
            end
          end
        end
      endcase
    end
    if (issue) begin
      m_brake = 1; m_src = isrc; m_phase = 1; m_n = 0;
      if (m_count < CMAX) m_count++;
      for (int i = 0; i < NSRC; i++) run_len[i] = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge refclk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  bit cmp_en = 0;
  initial begin
    forever begin
      @(negedge refclk);
      if (cmp_en) begin
        chk("brake", brake, m_brake);
        chk("brake_src", brake_src, m_src);
        chk("sched_busy", sched_busy, m_phase != 0);
        chk("event_count", event_count, m_count);
        chk("timeout_err", timeout_err, m_terr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge refclk);
    #2;
  endtask

  // Hold a request for exactly DEB samples; brake is high after the last one.
  task automatic trig(input logic [NSRC-1:0] bits);
    droop_req = bits;
    repeat (DEB) step();
    droop_req = '0;
  endtask

  task automatic wait_brake(input logic val, input int budget, input string name);
    int n;
    n = 0;
    while (brake !== val && n < budget) begin
      step();
      n++;
    end
    if (brake !== val) bound_fail(name);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (sched_busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    if (sched_busy !== 1'b0) bound_fail(name);
  endtask

  task automatic do_brake(input logic [NSRC-1:0] bits);
    brake_state = BRAKES_OFF;
    trig(bits);
    wait_idle(200, "do_brake_idle");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  int t_rise, t_fall, t_off, t_arm, saved;

  initial begin
    resetn = 1'b0; enable = 1'b1; src_mask = 4'hF; droop_req = '0;
    brake_state = BRAKING; clear_status = 1'b0;
    cmp_en = 1;
    repeat (3) step();
    chk("rst_brake", brake, 1'b0);
    chk("rst_busy", sched_busy, 1'b0);
    chk("rst_count", event_count, 0);
    chk("rst_src", brake_src, 0);
    chk("rst_terr", timeout_err, 1'b0);
    resetn = 1'b1;
    step();

    // Too-short request: two samples never qualify.
    droop_req = 4'b0100;
    step(); step();
    droop_req = '0;
    repeat (4) step();
    chk("short_brake", brake, 1'b0);
    chk("short_count", event_count, 0);

    // Source 1 high for five samples: brake after the third, width 8.
    droop_req = 4'b0010;
    step(); step();
    chk("lat_pre", brake, 1'b0);
    step();
    chk("lat_rise", brake, 1'b1);
    t_rise = cyc;
    step(); step();
    droop_req = '0;
    wait_brake(1'b0, 40, "width_fall");
    t_fall = cyc;
    chk("width", t_fall - t_rise, MINB);
    chk("src1", brake_src, 1);
    chk("count1", event_count, 1);
    repeat (19) step();
    brake_state = BRAKES_OFF;
    step();
    t_off = cyc;
    chk("holdoff_entry_busy", sched_busy, 1'b1);
    wait_idle(200, "rearm");
    t_arm = cyc;
    chk("rearm_delay", t_arm - t_off, HOLD + 1);

    // Priority: sources 3 and 0 together.
    trig(4'b1001);
    chk("prio_src0", brake_src, 0);
    chk("prio_brake", brake, 1'b1);
    wait_idle(200, "prio_idle0");
    src_mask = 4'b1110;
    trig(4'b1001);
    chk("prio_src3", brake_src, 3);
    wait_idle(200, "prio_idle3");
    src_mask = 4'hF;

    // Recovery timeout.
    brake_state = BRAKING;
    trig(4'b0001);
    wait_brake(1'b0, 40, "tmo_fall");
    t_fall = cyc;
    while (timeout_err !== 1'b1 && cyc - t_fall < DTO + 10) step();
    chk("tmo_set", timeout_err, 1'b1);
    chk("tmo_delay", cyc - t_fall, DTO);
    chk("tmo_holdoff", sched_busy, 1'b1);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    chk("clr_terr", timeout_err, 1'b0);
    chk("clr_count", event_count, 0);
    brake_state = BRAKES_OFF;
    wait_idle(200, "tmo_idle");

    // Abort four cycles into ASSERT.
    trig(4'b0010);
    saved = event_count;
    repeat (4) step();
    chk("abort_pre", brake, 1'b1);
    enable = 1'b0;
    step();
    chk("abort_brake", brake, 1'b0);
    chk("abort_busy", sched_busy, 1'b0);
    chk("abort_count", event_count, saved);
    enable = 1'b1;

    // Counter saturation.
    for (int k = 0; k < CMAX + 1; k++) do_brake(4'b0100);
    chk("sat_count", event_count, CMAX);

    // Request pulse during HOLDOFF.
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    trig(4'b0001);
    wait_brake(1'b0, 40, "pend_fall");
    t_fall = cyc;
    repeat (10) step();
    droop_req = 4'b0100;
    step();
    droop_req = '0;
    while (brake === 1'b0 && sched_busy === 1'b1 && cyc - t_fall < 200) step();
    chk("pend_exit_time", cyc - t_fall, HOLD + 2);
`ifdef DROOP_BRAKE_SCHED_PENDING_EN
    chk("pend_brake", brake, 1'b1);
    chk("pend_src", brake_src, 2);
    chk("pend_count", event_count, 2);
    wait_idle(200, "pend_idle");
`else
    chk("nopend_busy", sched_busy, 1'b0);
    repeat (5) step();
    chk("nopend_brake", brake, 1'b0);
    chk("nopend_count", event_count, 1);
`endif

    // Asynchronous reset mid-brake.
    trig(4'b1000);
    step();
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_brake", brake, 1'b0);
    chk("arst_count", event_count, 0);
    chk("arst_busy", sched_busy, 1'b0);
    step();
    resetn = 1'b1;
    repeat (3) step();

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/droop_brake_sched.md
Name: droop_brake_sched

Overview:
- Brake-request scheduler in front of the supply droop/recovery manager.
- Collects raw droop-detector requests from NUM_SRC sources, masks and debounces each one, and drives the single brake input of the droop manager.
- Enforces a minimum brake width and waits for the manager's recovery to finish (via brake_state), with a timeout.
- Applies a re-arm holdoff and keeps event and error status for the firmware/scan interface.

Parameters:
- NUM_SRC, 4: number of droop-request sources.
- DEBOUNCE_CYCLES, 3: consecutive high samples needed to qualify a request; must be >=1.
- MIN_BRAKE_CYCLES, 8: minimum cycles brake stays high; must be >=2.
- DONE_TIMEOUT, 4096: max cycles to wait for brake_state==BRAKES_OFF after brake drops.
- HOLDOFF_CYCLES, 64: re-arm lockout after recovery; 0 is legal.
- CNT_W, 16: event counter width.

Ports:
- refclk  in  1  reference clock; all logic is on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  scheduler enable.
- src_mask  in  NUM_SRC  1 = source may trigger a brake.
- droop_req  in  NUM_SRC  raw requests, synchronous to refclk.
- brake_state  in  brake_state_t  state fed back from the droop manager (BRAKES_OFF/BRAKING/RECOVERING).
- clear_status  in  1  synchronous clear of event_count and timeout_err.
- brake  out  1  registered brake request to the droop manager.
- brake_src  out  $clog2(NUM_SRC) (min 1)  index of the source that triggered the current/last brake.
- sched_busy  out  1  high in any state other than ARMED.
- event_count  out  CNT_W  number of brakes issued, saturating.
- timeout_err  out  1  sticky, set on DONE_TIMEOUT expiry.

Behaviour:
- Reset values:
  - brake=0, brake_src=0, event_count=0, timeout_err=0.
  - State=ARMED, all debounce/timer counters=0.
  - sched_busy is derived from state, so it is 0 in reset.
- Debounce, per source i (runs only in ARMED):
  - cnt_i increments while droop_req[i]&src_mask[i], saturating at DEBOUNCE_CYCLES-1; it clears on any low sample.
  - qual[i] = droop_req[i] & src_mask[i] & (cnt_i==DEBOUNCE_CYCLES-1).
  - With DEBOUNCE_CYCLES=1, the first high sample qualifies.
  - All cnt_i are held at 0 outside ARMED.
- ARMED:
  - If any qual bit is set, at that same edge: brake<=1, brake_src<=lowest qualifying index, event_count+=1 (saturating), timer<=MIN_BRAKE_CYCLES-1, next state ASSERT.
  - Latency: a request that is high from edge E1 gives brake=1 after edge E_DEBOUNCE_CYCLES.
- ASSERT:
  - Timer decrements to 0.
  - Leave when timer==0 and no masked raw request (droop_req&src_mask)==0. At that edge: brake<=0, timer<=DONE_TIMEOUT-1, next state WAIT_DONE.
  - Brake width is therefore >=MIN_BRAKE_CYCLES, extended while any masked request is still high.
- WAIT_DONE:
  - If brake_state==BRAKES_OFF: timer<=HOLDOFF_CYCLES, next state HOLDOFF.
  - Else if timer==0: timeout_err<=1, timer<=HOLDOFF_CYCLES, next state HOLDOFF.
  - Else timer decrements.
- HOLDOFF:
  - Timer decrements; at timer==0 go to ARMED.
  - With HOLDOFF_CYCLES=0 this state lasts one cycle.
  - Requests are ignored (see the optional feature).
- enable=0 (any state):
  - At the next edge: brake<=0, state<=ARMED, debounce and timers cleared.
  - event_count, timeout_err and brake_src are retained.
  - This acts as an abort, including mid-brake; the droop manager then completes its own recovery.
- clear_status:
  - Clears event_count and timeout_err at the edge.
  - If a brake issue coincides with the clear, event_count becomes 1.
  - If a timeout coincides with the clear, timeout_err ends at 1 (set wins).
- Mask changes take effect at once: unmasking resets nothing, and masking clears that source's cnt_i at the next edge.
- Asynchronous reset mid-operation returns every register to its reset value immediately; brake drops asynchronously.

Optional Feature:
- Macro: DROOP_BRAKE_SCHED_PENDING_EN.
- When defined:
  - A pending register captures any masked raw request seen during WAIT_DONE or HOLDOFF (lowest index kept; first capture holds).
  - On the HOLDOFF->ARMED edge a pending request goes straight to ASSERT with no debounce: brake=1, brake_src=captured index, count+1; pending then clears.
  - enable=0 also clears pending.
- When not defined: requests outside ARMED are discarded, and a request still high on re-arm must debounce again.

Test Plan:
- Defaults; droop_req[2]=1 held for 2 cycles then 0 -> brake never rises, event_count=0.
- droop_req[1]=1 from E1 for 5 cycles, brake_state returns BRAKES_OFF 20 cycles after brake falls -> brake high after E3, high exactly 8 cycles, brake_src=1, event_count=1; re-arm (sched_busy=0) 65 cycles after BRAKES_OFF seen.
- Sources 3 and 0 qualify on the same edge with src_mask=4'b1111 -> brake_src=0; repeat with src_mask=4'b1110 -> brake_src=3.
- DONE_TIMEOUT=16 and brake_state stuck at BRAKING -> timeout_err=1 16 cycles after brake falls, HOLDOFF entered; clear_status pulse -> timeout_err=0, event_count=0.
- enable dropped 4 cycles into ASSERT -> brake=0 at the next edge, sched_busy=0, event_count unchanged; event_count at 16'hFFFF plus one more brake stays at 16'hFFFF.
- With PENDING_EN: request pulse (1 cycle) during HOLDOFF -> brake=1 on the HOLDOFF->ARMED edge, no debounce delay; without the macro -> no brake.
